// File: rtl/blackjack_round_ctrl_pkg.sv
// blackjack_pkg: shared types and constants for the 17-point round sequencer.
//   state_t        - round FSM state encoding (also exported on the debug port)
//   CARD_MIN/MAX   - legal card value range
//   DEFAULT_TARGET - default winning hand sum
//   SUM_W          - hand sum width (7 cards x 9 points = 63 fits in 6 bits)
//   card_legal()   - legality check for a presented card value
package blackjack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EVAL   = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int CARD_MIN       = 1;
  localparam int CARD_MAX       = 9;
  localparam int DEFAULT_TARGET = 17;
  localparam int SUM_W          = 6;

  function automatic logic card_legal(input logic [3:0] v);
    return (v >= 4'(CARD_MIN)) && (v <= 4'(CARD_MAX));
  endfunction

endpackage

// File: rtl/blackjack_round_ctrl_card_fetch.sv
// card_fetch: card source handshake for the round sequencer.
//   clk, rst    - clock, synchronous active-high reset
//   req_next    - FSM's next-cycle request (next state is FETCH)
//   card_valid  - source has a card on card_value
//   card_value  - presented card value (legal 1..9)
//   card_req    - registered request to the card source
//   accept      - strobe: a legal card is taken on this edge
module card_fetch
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_next,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic       card_req,
  output logic       accept
);

  // Request is registered from the FSM's next state so it is high exactly
  // in the FETCH cycles, and drops in the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) card_req <= 1'b0;
    else     card_req <= req_next;
  end

  // Illegal values are simply not accepted; the request stays up.
  assign accept = card_req && card_valid && card_legal(card_value);

endmodule

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: round sequencer for the 17-point card game.
// Requests cards, accumulates the hand, takes hit/stand decisions and
// issues single-cycle win/lose pulses.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start                  - begin a round (IDLE or DONE only)
//   hit, stand             - player decision, sampled in DECIDE only
//   card_req/valid/value   - card source handshake
//   card_count, hand_sum   - cards accepted / running sum this round
//   state                  - FSM state encoding for debug/display
//   busy                   - high except in IDLE and DONE
//   win_pulse, lose_pulse  - one-cycle result indications
//   round_done             - high in DONE
// Optional feature macro: ROUND_TIMEOUT_EN (decide-phase timeout of
// TIMEOUT_CYC cycles, treated as stand).
module blackjack_round_ctrl
  import blackjack_pkg::*;
#(
  parameter int TARGET      = DEFAULT_TARGET,
  parameter int MAX_CARDS   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hit,
  input  logic             stand,
  output logic             card_req,
  input  logic             card_valid,
  input  logic [3:0]       card_value,
  output logic [2:0]       card_count,
  output logic [SUM_W-1:0] hand_sum,
  output logic [2:0]       state,
  output logic             busy,
  output logic             win_pulse,
  output logic             lose_pulse,
  output logic             round_done
);

  state_t cur_st, nxt_st;
  logic   accept;
  logic   clr_hand;
  logic   win_next, lose_next;
  logic   tmo_hit;

  card_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .req_next   (nxt_st == FETCH),
    .card_valid (card_valid),
    .card_value (card_value),
    .card_req   (card_req),
    .accept     (accept)
  );

`ifdef ROUND_TIMEOUT_EN
  // Counter is zero on DECIDE entry and counts each DECIDE cycle; the
  // timeout fires so that DONE is reached TIMEOUT_CYC edges after entry.
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || cur_st != DECIDE) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (cur_st == DECIDE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  // No timeout: DECIDE waits indefinitely. TIMEOUT_CYC kept for a uniform
  // parameter list across builds.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) cur_st <= IDLE;
    else     cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st    = cur_st;
    clr_hand  = 1'b0;
    win_next  = 1'b0;
    lose_next = 1'b0;
    unique case (cur_st)
      IDLE, DONE: begin
        if (start) begin
          nxt_st   = FETCH;
          clr_hand = 1'b1;
        end
      end
      FETCH: begin
        if (accept) nxt_st = EVAL;
      end
      EVAL: begin
        if (hand_sum == SUM_W'(TARGET)) begin
          win_next = 1'b1;
          nxt_st   = DONE;
        end else if (hand_sum > SUM_W'(TARGET)) begin
          lose_next = 1'b1;
          nxt_st    = DONE;
        end else if (card_count < 3'd2) begin
          nxt_st = FETCH;
        end else if (card_count == 3'(MAX_CARDS)) begin
          lose_next = 1'b1;
          nxt_st    = DONE;
        end else begin
          nxt_st = DECIDE;
        end
      end
      DECIDE: begin
        // Stand beats hit; a decision in the terminal cycle beats timeout.
        if (stand || (!hit && tmo_hit)) begin
          lose_next = 1'b1;
          nxt_st    = DONE;
        end else if (hit) begin
          nxt_st = FETCH;
        end
      end
      default: nxt_st = IDLE;
    endcase
  end

  // Registered outputs and hand accumulator; a card presented in a reset
  // cycle is discarded because reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      hand_sum   <= '0;
      card_count <= '0;
      win_pulse  <= 1'b0;
      lose_pulse <= 1'b0;
      round_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (clr_hand) begin
        hand_sum   <= '0;
        card_count <= '0;
      end else if (accept) begin
        hand_sum   <= hand_sum + SUM_W'(card_value);
        card_count <= card_count + 3'd1;
      end
      win_pulse  <= win_next;
      lose_pulse <= lose_next;
      round_done <= (nxt_st == DONE);
      busy       <= (nxt_st != IDLE) && (nxt_st != DONE);
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Testbench for blackjack_round_ctrl: directed and randomized rounds checked
// against a game-rule reference model.
module tb_blackjack_round_ctrl;
  import blackjack_pkg::*;

  localparam int T  = 17;
  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst, start, hit, stand, card_valid;
  logic [3:0] card_value;
  logic       card_req, busy, win_pulse, lose_pulse, round_done;
  logic [2:0] card_count, st_dbg;
  logic [5:0] hand_sum;

  blackjack_round_ctrl #(.TARGET(T), .MAX_CARDS(MC), .TIMEOUT_CYC(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .stand      (stand),
    .card_req   (card_req),
    .card_valid (card_valid),
    .card_value (card_value),
    .card_count (card_count),
    .hand_sum   (hand_sum),
    .state      (st_dbg),
    .busy       (busy),
    .win_pulse  (win_pulse),
    .lose_pulse (lose_pulse),
    .round_done (round_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cq[$];
  int bq[$];
  int dq[$];
  bit use_waits;
  int dec_gap_max;

  // Reference: plays the round by the game rules. Decisions: 1 hit,
  // 2 stand, 3 both (stand wins). No decision left means lose by timeout.
  function automatic void model(input int cards[$], input int decs[$],
                                output int win, output int sum, output int cnt);
    int ci, di;
    ci = 0; di = 0; win = 0;
    sum = cards[ci]; ci++; cnt = 1;
    for (int g = 0; g < 20; g++) begin
      if (sum == T) begin win = 1; return; end
      if (sum > T) return;
      if (cnt < 2) begin
        sum += cards[ci]; ci++; cnt++;
      end else if (cnt == MC) begin
        return;
      end else begin
        if (di >= decs.size()) return;
        if (decs[di] >= 2) return;
        di++;
        sum += cards[ci]; ci++; cnt++;
      end
    end
  endfunction

  task automatic run_round(output int wins, output int loses, output int ncyc,
                           output int nlast);
    int  n, acc, gap, d;
    bit  dec_on, presented;
    n = 0; acc = 0; gap = 0; dec_on = 0;
    wins = 0; loses = 0; ncyc = -1; nlast = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n <= 400) begin
      wins  += int'(win_pulse);
      loses += int'(lose_pulse);
      if (round_done) begin ncyc = n; break; end
      hit = 1'b0; stand = 1'b0; card_valid = 1'b0; card_value = 4'd0;
      presented = 1'b0;
      if (card_req) begin
        if (dec_on) begin
          dec_on = 1'b0;
          void'(dq.pop_front());
        end
        if (bq.size() > 0) begin
          card_valid = 1'b1;
          card_value = 4'(bq.pop_front());
        end else if (use_waits && $urandom_range(0, 2) == 0) begin
          card_valid = 1'b0;
        end else begin
          card_valid = 1'b1;
          card_value = 4'(cq[0]);
          presented  = 1'b1;
        end
      end else if (dec_on) begin
        if (gap > 0) gap--;
        else if (dq.size() > 0) begin
          d = dq[0];
          hit   = d[0];
          stand = d[1];
        end
      end
      @(posedge clk); #1;
      n++;
      if (presented) begin
        void'(cq.pop_front());
        acc++;
        nlast = n;
        if (acc >= 2) begin
          dec_on = 1'b1;
          gap = $urandom_range(0, dec_gap_max);
        end
      end
    end
    hit = 1'b0; stand = 1'b0; card_valid = 1'b0; card_value = 4'd0;
  endtask

  task automatic do_round(input string tag, input int cards[$], input int bads[$],
                          input int decs[$], input bit waits, input int gapmax,
                          input int exp_lat);
    int ew, es, ec, w, l, nc, nl, extra;
    model(cards, decs, ew, es, ec);
    cq = cards; bq = bads; dq = decs;
    use_waits = waits; dec_gap_max = gapmax;
    run_round(w, l, nc, nl);
    check_val({tag, ".ended"}, int'(nc >= 0), 1);
    check_val({tag, ".win"}, w, ew);
    check_val({tag, ".lose"}, l, 1 - ew);
    check_val({tag, ".sum"}, int'(hand_sum), es);
    check_val({tag, ".count"}, int'(card_count), ec);
    check_val({tag, ".done"}, int'(round_done), 1);
    check_val({tag, ".busy"}, int'(busy), 0);
    check_val({tag, ".state"}, int'(st_dbg), int'(DONE));
    if (exp_lat >= 0) check_val({tag, ".lat"}, nc, exp_lat);
    // Extra hits in DONE must be ignored and no pulse repeats.
    extra = 0;
    hit = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      extra += int'(win_pulse) + int'(lose_pulse) + int'(card_req);
    end
    hit = 1'b0;
    check_val({tag, ".hold_quiet"}, extra, 0);
    check_val({tag, ".hold_sum"}, int'(hand_sum), es);
    check_val({tag, ".hold_done"}, int'(round_done), 1);
  endtask

  int cards_r[$], bads_r[$], decs_r[$], none[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0;
    card_valid = 1'b0; card_value = 4'd0;
    none = {};
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.state", int'(st_dbg), int'(IDLE));
    check_val("rst.req", int'(card_req), 0);
    check_val("rst.pulses", int'(win_pulse) + int'(lose_pulse), 0);
    check_val("rst.done", int'(round_done), 0);
    check_val("rst.busy", int'(busy), 0);
    check_val("rst.count", int'(card_count), 0);
    check_val("rst.sum", int'(hand_sum), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_round("d89",   '{8, 9, 1, 1}, none, none, 0, 0, 4);
    do_round("d99",   '{9, 9, 1, 1}, none, '{1, 1}, 0, 0, 4);
    do_round("d56h6", '{5, 6, 6, 1}, none, '{1}, 0, 0, -1);
    do_round("d56hs", '{5, 6, 6, 1}, none, '{3}, 0, 0, -1);
    do_round("dmax",  '{2, 3, 4, 5, 1}, none, '{1, 1, 1}, 0, 1, -1);
    do_round("dbad",  '{7, 9, 1, 1}, '{0, 10}, '{2}, 0, 0, -1);

    // Reset mid-handshake: card presented in the reset cycle is discarded.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("mid.req_up", int'(card_req), 1);
    card_valid = 1'b1; card_value = 4'd5; rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid.req", int'(card_req), 0);
    check_val("mid.sum", int'(hand_sum), 0);
    check_val("mid.count", int'(card_count), 0);
    check_val("mid.busy", int'(busy), 0);
    check_val("mid.state", int'(st_dbg), int'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    card_valid = 1'b0; card_value = 4'd0;
    check_val("mid.stay_idle", int'(st_dbg), int'(IDLE));
    check_val("mid.count2", int'(card_count), 0);

`ifdef ROUND_TIMEOUT_EN
    begin
      int w, l, nc, nl;
      cq = '{4, 4, 1, 1}; bq = {}; dq = {};
      use_waits = 0; dec_gap_max = 0;
      run_round(w, l, nc, nl);
      check_val("tmo.lose", l, 1);
      check_val("tmo.win", w, 0);
      check_val("tmo.lat", nc - nl, 21);
      check_val("tmo.sum", int'(hand_sum), 8);
    end
`endif

    for (int r = 0; r < 40; r++) begin
      cards_r = {}; bads_r = {}; decs_r = {};
      for (int i = 0; i < 8; i++) cards_r.push_back(int'($urandom_range(1, 9)));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        int v;
        v = int'($urandom_range(0, 6));
        bads_r.push_back(v == 0 ? 0 : 9 + v);
      end
      for (int i = 0; i < 8; i++) decs_r.push_back(int'($urandom_range(1, 3)));
      do_round($sformatf("rnd%0d", r), cards_r, bads_r, decs_r, 1, 3, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
